// File: rtl/sr_cmd_pkg.sv
// Shared constants and FSM encoding for the SR command generator.
package sr_cmd_pkg;

   localparam int DB_CYCLES_DEF    = 4;
   localparam int GUARD_CYCLES_DEF = 2;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE      = 2'd0;
   localparam state_t ST_SET_PULSE = 2'd1;
   localparam state_t ST_RST_PULSE = 2'd2;
   localparam state_t ST_GUARD     = 2'd3;

endpackage

// File: rtl/sr_debounce.sv
// Two-flop synchroniser plus debounce counter for one raw push-button;
// emits a one-cycle combinational press strobe on each accepted 0->1 level change.
module sr_debounce
   import sr_cmd_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic press_o
);

   localparam int CW = $clog2(DB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          diff;
   logic          hit;

   // The counter only runs while the synchronised value disagrees with the
   // accepted level; any agreeing sample restarts the qualification window.
   always_comb begin
      diff    = sync_q[1] ^ level_q;
      hit     = diff && (cnt_q == CNT_LAST);
      cnt_d   = '0;
      if (diff && !hit) begin
         cnt_d = cnt_q + 1'b1;
      end
      level_d = level_q ^ hit;
      press_o = hit & ~level_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], btn_i};
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

endmodule

// File: rtl/sr_cmd_gen.sv
// Converts debounced set/reset button presses into mutually exclusive one-cycle
// s/r commands, with a post-command lockout window and a simultaneous-press flag.
module sr_cmd_gen
   import sr_cmd_pkg::*;
#(
   parameter int DB_CYCLES    = DB_CYCLES_DEF,
   parameter int GUARD_CYCLES = GUARD_CYCLES_DEF
) (
   input  logic clock,
   input  logic reset,
   input  logic set_btn,
   input  logic rst_btn,
   output logic s,
   output logic r,
   output logic busy,
   output logic conflict
);

   localparam int GW    = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
   localparam int GLAST = (GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0;
   localparam logic [GW-1:0] GLAST_C = GW'(GLAST);

   logic set_ev;
   logic rst_ev;

   state_t        state_q, state_d;
   logic [GW-1:0] gcnt_q, gcnt_d;
   logic          s_q, r_q, busy_q, conflict_q;
   logic          conflict_d;

   sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_set_db (
      .clk_i   (clock),
      .rst_i   (reset),
      .btn_i   (set_btn),
      .press_o (set_ev)
   );

   sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_rst_db (
      .clk_i   (clock),
      .rst_i   (reset),
      .btn_i   (rst_btn),
      .press_o (rst_ev)
   );

   // Presses arriving outside IDLE are simply dropped; nothing is queued.
   always_comb begin
      state_d    = state_q;
      gcnt_d     = gcnt_q;
      conflict_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (set_ev && rst_ev) begin
               conflict_d = 1'b1;
            end else if (set_ev) begin
               state_d = ST_SET_PULSE;
            end else if (rst_ev) begin
               state_d = ST_RST_PULSE;
            end
         end
         ST_SET_PULSE, ST_RST_PULSE: begin
            gcnt_d = '0;
            if (GUARD_CYCLES == 0) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_GUARD;
            end
         end
         ST_GUARD: begin
            if (gcnt_q == GLAST_C) begin
               state_d = ST_IDLE;
            end else begin
               gcnt_d = gcnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they come straight off flops.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         gcnt_q     <= '0;
         s_q        <= 1'b0;
         r_q        <= 1'b0;
         busy_q     <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gcnt_q     <= gcnt_d;
         s_q        <= (state_d == ST_SET_PULSE);
         r_q        <= (state_d == ST_RST_PULSE);
         busy_q     <= (state_d != ST_IDLE);
         conflict_q <= conflict_d;
      end
   end

   assign s        = s_q;
   assign r        = r_q;
   assign busy     = busy_q;
   assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed bench for sr_cmd_gen with default parameters (DB_CYCLES=4, GUARD_CYCLES=2).
module tb_sr_cmd_gen;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic set_btn = 1'b0;
   logic rst_btn = 1'b0;
   logic s, r, busy, conflict;

   int checks = 0;
   int errors = 0;

   sr_cmd_gen dut (
      .clock    (clock),
      .reset    (reset),
      .set_btn  (set_btn),
      .rst_btn  (rst_btn),
      .s        (s),
      .r        (r),
      .busy     (busy),
      .conflict (conflict)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_bit(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic chk(input string tag, input logic es, input logic er,
                      input logic eb, input logic ec);
      chk_bit({tag, ".s"}, s, es);
      chk_bit({tag, ".r"}, r, er);
      chk_bit({tag, ".busy"}, busy, eb);
      chk_bit({tag, ".conflict"}, conflict, ec);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      logic prev_s, prev_r;
      int   last_start;
      int   cmds;

      // Reset state
      tick();
      tick();
      chk("in_reset", 0, 0, 0, 0);
      reset = 1'b0;
      tick();
      chk("post_reset", 0, 0, 0, 0);
      chk_bit("post_reset.set_level", dut.u_set_db.level_q, 1'b0);
      chk_bit("post_reset.rst_level", dut.u_rst_db.level_q, 1'b0);

      // Single press: s after E5, busy for three cycles
      set_btn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("single_wait", 0, 0, 0, 0);
      end
      tick(); chk("single_pulse", 1, 0, 1, 0);
      tick(); chk("single_g1", 0, 0, 1, 0);
      tick(); chk("single_g2", 0, 0, 1, 0);
      tick(); chk("single_done", 0, 0, 0, 0);
      set_btn = 1'b0;
      idle(10);
      chk_bit("single_release_level", dut.u_set_db.level_q, 1'b0);

      // Glitch: three synchronised high cycles is one short of acceptance
      set_btn = 1'b1;
      idle(3);
      set_btn = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("glitch", 0, 0, 0, 0);
      end
      chk_bit("glitch_level", dut.u_set_db.level_q, 1'b0);

      // Simultaneous press raises conflict only, then a lone rst re-press
      set_btn = 1'b1;
      rst_btn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("sim_wait", 0, 0, 0, 0);
      end
      tick(); chk("sim_conflict", 0, 0, 0, 1);
      tick(); chk("sim_clear", 0, 0, 0, 0);
      rst_btn = 1'b0;
      idle(8);
      chk("sim_release", 0, 0, 0, 0);
      rst_btn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("sim_rewait", 0, 0, 0, 0);
      end
      tick(); chk("sim_r_pulse", 0, 1, 1, 0);
      tick(); chk("sim_r_end", 0, 0, 1, 0);
      set_btn = 1'b0;
      rst_btn = 1'b0;
      idle(12);
      chk("sim_idle", 0, 0, 0, 0);

      // rst press event lands while in GUARD, one cycle after the s pulse
      set_btn = 1'b1;
      tick(); chk("guard_w0", 0, 0, 0, 0);
      tick(); chk("guard_w1", 0, 0, 0, 0);
      rst_btn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("guard_w", 0, 0, 0, 0);
      end
      tick(); chk("guard_s", 1, 0, 1, 0);
      tick(); chk("guard_g1", 0, 0, 1, 0);
      tick(); chk("guard_g2", 0, 0, 1, 0);
      tick(); chk("guard_done", 0, 0, 0, 0);
      chk_bit("guard_rst_level", dut.u_rst_db.level_q, 1'b1);
      tick(); chk("guard_after", 0, 0, 0, 0);
      set_btn = 1'b0;
      rst_btn = 1'b0;
      idle(12);

      // Asynchronous reset during SET_PULSE with set_btn held
      set_btn = 1'b1;
      idle(5);
      tick(); chk("mid_pulse", 1, 0, 1, 0);
      #2 reset = 1'b1;
      #1 chk("mid_reset", 0, 0, 0, 0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("mid_rewait", 0, 0, 0, 0);
      end
      tick(); chk("mid_repulse", 1, 0, 1, 0);
      tick(); chk("mid_repulse_end", 0, 0, 1, 0);
      set_btn = 1'b0;
      idle(12);

      // Random bounce soak
      prev_s = 1'b0;
      prev_r = 1'b0;
      last_start = -100;
      cmds = 0;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 15) == 0) set_btn = ~set_btn;
         if ($urandom_range(0, 15) == 0) rst_btn = ~rst_btn;
         tick();
         chk_bit("soak_s_and_r", s & r, 1'b0);
         if (prev_s) chk_bit("soak_s_width", s, 1'b0);
         if (prev_r) chk_bit("soak_r_width", r, 1'b0);
         if ((s && !prev_s) || (r && !prev_r)) begin
            chk_bit("soak_cmd_spacing", (i - last_start) >= 3, 1'b1);
            last_start = i;
            cmds++;
         end
         prev_s = s;
         prev_r = r;
      end
      chk_bit("soak_cmds_seen", cmds > 0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
